// File: rtl/mem_access_seq_pkg.sv
// mem_seq_pkg: shared definitions for the memory access sequencer.
//   - op codes, size codes, FSM state enum
//   - trap codes
//   - RAM_OpCode field layout
//   - misalignment helper
package mem_seq_pkg;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAR,
        ACCESS,
        CAPTURE,
        DONE,
        TRAP
    } state_e;

    localparam logic [2:0] TT_NONE     = 3'd0;
    localparam logic [2:0] TT_MISALIGN = 3'd1;
    localparam logic [2:0] TT_TIMEOUT  = 3'd2;

    // RAM_OpCode = {2'b00, signed, write, size[1:0]}
    typedef struct packed {
        logic [1:0] rsvd;
        logic       sgn;
        logic       write;
        logic [1:0] size;
    } ram_opcode_t;

    // Bytes are always aligned; halfwords need addr[0]=0; word (and the
    // reserved size code) need both low bits clear.
    function automatic logic misaligned(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: request/RAM-control bundle between the control unit,
// the RAM and the sequencer.
//   master: drives req/op/size/ld_signed/addr_low/MFC, observes strobes.
//   slave : the sequencer; consumes the request, drives all strobes/status.
interface mem_access_seq_if;
    logic       req;
    logic [1:0] op;
    logic [1:0] size;
    logic       ld_signed;
    logic [1:0] addr_low;
    logic       MFC;
    logic       MAR_Enable;
    logic       RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       IR_Enable;
    logic       MDR_Enable;
    logic       MDR_Mux_select;
    logic       busy;
    logic       done;
    logic       trap_valid;
    logic [2:0] trap_tt;

    modport master (
        output req, op, size, ld_signed, addr_low, MFC,
        input  MAR_Enable, RAM_enable, RAM_OpCode, IR_Enable, MDR_Enable,
               MDR_Mux_select, busy, done, trap_valid, trap_tt
    );

    modport slave (
        input  req, op, size, ld_signed, addr_low, MFC,
        output MAR_Enable, RAM_enable, RAM_OpCode, IR_Enable, MDR_Enable,
               MDR_Mux_select, busy, done, trap_valid, trap_tt
    );
endinterface

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts ACCESS cycles spent waiting for MFC.
//   Clk/Clr : clock, async active-high reset
//   clr     : synchronous clear (dominates en)
//   en      : increment
//   tc      : count has reached TIMEOUT-1
module mem_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic Clk,
    input  logic Clr,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: turns one fetch/load/store request into MAR load, RAM
// strobe, MFC wait and IR/MDR capture, ending in a done or trap pulse.
//   Clk/Clr : clock, async active-high reset
//   bus     : mem_access_seq_if.slave (request in, RAM/datapath strobes out)
// All outputs are decoded from registered state and latched fields only.
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic               Clk,
    input  logic               Clr,
    mem_access_seq_if.slave    bus
);
    state_e      state_q, state_d;
    op_e         op_q, op_d;
    size_e       size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [2:0]  tt_q, tt_d;
    logic        cnt_clr, cnt_en, cnt_tc;
    ram_opcode_t opcode;

    // Clearing whenever we are outside ACCESS guarantees a zero count on
    // every entry into ACCESS.
    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .Clk (Clk),
        .Clr (Clr),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        tt_d    = tt_q;
        cnt_clr = (state_q != ACCESS);
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d = LOAD_MAR;
                tt_d    = TT_NONE;
                // Reserved op behaves as a load; fetch is always a word.
                case (op_e'(bus.op))
                    OP_FETCH: op_d = OP_FETCH;
                    OP_STORE: op_d = OP_STORE;
                    default:  op_d = OP_LOAD;
                endcase
                size_d = (op_e'(bus.op) == OP_FETCH) ? SZ_WORD : size_e'(bus.size);
                sgn_d  = bus.ld_signed &&
                         (op_e'(bus.op) == OP_LOAD || op_e'(bus.op) == OP_RSVD);
            end
            LOAD_MAR: begin
                if (misaligned(size_q, bus.addr_low)) begin
                    state_d = TRAP;
                    tt_d    = TT_MISALIGN;
                end else begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // MFC beats a simultaneous timeout.
                if (bus.MFC) begin
                    state_d = CAPTURE;
                end else if (cnt_tc) begin
                    state_d = TRAP;
                    tt_d    = TT_TIMEOUT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            TRAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= IDLE;
            op_q    <= OP_FETCH;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            tt_q    <= TT_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            tt_q    <= tt_d;
        end
    end

    always_comb begin
        opcode.rsvd  = 2'b00;
        opcode.sgn   = sgn_q;
        opcode.write = (op_q == OP_STORE);
        opcode.size  = size_q;

        bus.MAR_Enable     = (state_q == LOAD_MAR);
        bus.RAM_enable     = (state_q == ACCESS) || (state_q == CAPTURE);
        // Opcode only presented while the RAM is strobed; zero otherwise.
        bus.RAM_OpCode     = bus.RAM_enable ? opcode : 6'd0;
        bus.IR_Enable      = (state_q == CAPTURE) && (op_q == OP_FETCH);
        bus.MDR_Enable     = (state_q == CAPTURE) && (op_q == OP_LOAD);
        bus.MDR_Mux_select = (state_q == CAPTURE) && (op_q == OP_LOAD);
        bus.busy           = (state_q != IDLE);
        bus.done           = (state_q == DONE);
        bus.trap_valid     = (state_q == TRAP);
        bus.trap_tt        = tt_q;
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: directed scenarios plus randomized requests,
// each compared cycle by cycle against a timeline model built from the
// request's op/size/address and the number of MFC wait cycles.
module tb_mem_access_seq;
    localparam int T = 15;

    logic clk;
    logic clr;
    int   nvec;
    int   nerr;

    mem_access_seq_if bus();

    mem_access_seq #(.TIMEOUT(T)) dut (
        .Clk (clk),
        .Clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {MAR, RAMen, opcode[5:0], IR, MDR, mux, busy, done, trap_valid, tt[2:0]}
    function automatic logic [16:0] obs();
        return {bus.MAR_Enable, bus.RAM_enable, bus.RAM_OpCode, bus.IR_Enable,
                bus.MDR_Enable, bus.MDR_Mux_select, bus.busy, bus.done,
                bus.trap_valid, bus.trap_tt};
    endfunction

    // One request: accepted at edge 0, MFC low for w ACCESS cycles then high.
    // Each cycle 1..end+1 is compared against the expected timeline.
    task automatic run_txn(input string name, input logic [1:0] op,
                           input logic [1:0] sz, input logic sg,
                           input logic [1:0] a, input int w, input bit noise);
        logic [1:0]  esz;
        logic        esg, is_ld, mis, to;
        int          e_end, ren_last;
        logic [16:0] exp_v, got;
        logic        mar, ren, cap, dn, tv;
        logic [5:0]  oc;
        logic [2:0]  tt;

        is_ld = (op == 2'b01) || (op == 2'b11);
        esz   = (op == 2'b00) ? 2'b10 : sz;
        esg   = sg && is_ld;
        case (esz)
            2'b00:   mis = 1'b0;
            2'b01:   mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        to       = !mis && (w >= T);
        e_end    = mis ? 2 : (to ? T + 2 : w + 4);
        ren_last = to ? T + 1 : w + 3;

        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = op; bus.size = sz; bus.ld_signed = sg;
        bus.addr_low = a; bus.MFC = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= e_end + 1; k++) begin
            #1;
            bus.req = (noise && k <= e_end) ? 1'($urandom_range(1)) : 1'b0;
            if (noise) begin
                bus.op        = 2'($urandom_range(3));
                bus.size      = 2'($urandom_range(3));
                bus.ld_signed = 1'($urandom_range(1));
            end
            bus.MFC = (k >= w + 2);
            @(negedge clk);
            mar = (k == 1);
            ren = !mis && k >= 2 && k <= ren_last;
            oc  = ren ? {2'b00, esg, (op == 2'b10), esz} : 6'd0;
            cap = !mis && !to && (k == w + 3);
            dn  = !mis && !to && (k == e_end);
            tv  = (mis || to) && (k == e_end);
            tt  = (k >= e_end) ? (mis ? 3'd1 : (to ? 3'd2 : 3'd0)) : 3'd0;
            exp_v = {mar, ren, oc, cap && op == 2'b00, cap && is_ld, cap && is_ld,
                     (k <= e_end), dn, tv, tt};
            got = obs();
            nvec++;
            if (got !== exp_v) begin
                nerr++;
                $display("FAIL %s cycle %0d: got %05h expected %05h", name, k, got, exp_v);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.req = 1'b0; bus.op = 2'b00; bus.size = 2'b00; bus.ld_signed = 1'b0;
        bus.addr_low = 2'b00; bus.MFC = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if (obs() !== 17'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got %05h expected %05h", obs(), 17'd0);
        end
        clr = 1'b0;
    endtask

    task automatic test_fetch();
        run_txn("fetch_fast", 2'b00, 2'b11, 1'b1, 2'b00, 0, 1'b0);
    endtask

    task automatic test_load_wait();
        run_txn("half_load_signed_wait3", 2'b01, 2'b01, 1'b1, 2'b10, 3, 1'b0);
        run_txn("byte_load_unsigned", 2'b01, 2'b00, 1'b0, 2'b11, 1, 1'b0);
        run_txn("rsvd_op_as_load", 2'b11, 2'b10, 1'b1, 2'b00, 0, 1'b0);
        run_txn("word_store", 2'b10, 2'b10, 1'b1, 2'b00, 2, 1'b0);
    endtask

    task automatic test_misalign();
        run_txn("store_word_mis", 2'b10, 2'b10, 1'b0, 2'b01, 0, 1'b0);
        run_txn("half_load_mis", 2'b01, 2'b01, 1'b0, 2'b11, 0, 1'b0);
        run_txn("fetch_mis", 2'b00, 2'b00, 1'b0, 2'b10, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("byte_load_timeout", 2'b01, 2'b00, 1'b0, 2'b00, 100, 1'b0);
        run_txn("mfc_last_access", 2'b01, 2'b00, 1'b0, 2'b00, T - 1, 1'b0);
        run_txn("timeout_again", 2'b10, 2'b00, 1'b0, 2'b01, T, 1'b0);
    endtask

    task automatic test_clr_abort();
        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = 2'b00; bus.addr_low = 2'b00; bus.MFC = 1'b0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (2) @(posedge clk);  // now in the second ACCESS cycle
        #1 clr = 1'b1;
        #1;
        nvec++;
        if (obs() !== 17'd0) begin
            nerr++;
            $display("FAIL clr_abort_async: got %05h expected %05h", obs(), 17'd0);
        end
        @(posedge clk); #1 clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.MFC = 1'b1;
            @(negedge clk);
            nvec++;
            if (obs() !== 17'd0) begin
                nerr++;
                $display("FAIL clr_abort_idle cycle %0d: got %05h expected %05h", k, obs(), 17'd0);
            end
            @(posedge clk); #1;
        end
        run_txn("fetch_after_clr", 2'b00, 2'b00, 1'b0, 2'b00, 1, 1'b1);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op, sz, a;
            logic       sg;
            int         w;
            op = 2'($urandom_range(3));
            sz = 2'($urandom_range(2));
            a  = 2'($urandom_range(3));
            sg = 1'($urandom_range(1));
            w  = ($urandom_range(9) == 0) ? (T - 1 + $urandom_range(2)) : $urandom_range(4);
            run_txn("random", op, sz, sg, a, w, 1'b1);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_fetch();
        test_load_wait();
        test_misalign();
        test_timeout();
        test_clr_abort();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Memory access sequencer sitting directly upstream of the datapath's memory ports. The control unit issues one fetch, load or store request; the sequencer drives the MAR load, the RAM enable/opcode and the IR/MDR capture strobes. It waits on the RAM's MFC handshake and reports completion, or raises a trap on misalignment or timeout. It turns each memory access into a single request/done exchange for the control FSM.

## Interface

Parameters:
- TIMEOUT, 15: maximum ACCESS cycles without MFC before a timeout trap (≥2).

Ports:
- Clk  in  1  clock, rising edge.
- Clr  in  1  reset; one clock, asynchronous active-high.
- req  in  1  start request, sampled only in IDLE.
- op  in  2  00 fetch, 01 load, 10 store, 11 reserved (treated as load).
- size  in  2  00 byte, 01 halfword, 10 word; ignored for fetch (forced word).
- ld_signed  in  1  sign-extend a load; ignored for fetch and store.
- addr_low  in  2  ALU_out[1:0], valid during LOAD_MAR.
- MFC  in  1  memory function complete from RAM.
- MAR_Enable  out  1  load MAR from ALU_out.
- RAM_enable  out  1  RAM access strobe.
- RAM_OpCode  out  6  {2'b00, signed, write, size[1:0]}.
- IR_Enable  out  1  capture RAM_Out into IR (fetch).
- MDR_Enable  out  1  capture into MDR (load).
- MDR_Mux_select  out  1  1 = RAM_Out path; 0 otherwise.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- trap_valid  out  1  one-cycle trap pulse.
- trap_tt  out  3  trap code, held until next accepted req.

## Operation

- op, size and ld_signed are latched when req is accepted in IDLE. req is ignored while busy.
- States and transitions:
  - IDLE: on req, go to LOAD_MAR.
  - LOAD_MAR: MAR_Enable=1 for exactly one cycle. Misaligned goes to TRAP; otherwise go to ACCESS.
  - ACCESS: RAM_enable=1 and RAM_OpCode stable. Sampling MFC=1 goes to CAPTURE.
  - CAPTURE: RAM_enable stays 1. Fetch: IR_Enable=1. Load: MDR_Enable=1 and MDR_Mux_select=1. Store: no capture strobe. Always goes to DONE.
  - DONE: done=1, then IDLE.
  - TRAP: trap_valid=1, then IDLE.
- Misaligned means one of:
  - halfword with addr_low[0]=1;
  - word or fetch with addr_low≠00.
- On misalignment: trap_tt=3'd1, and RAM_enable is never asserted for that request.
- Timeout:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with MFC=0.
  - When MFC=0 and the count equals TIMEOUT-1, go to TRAP with trap_tt=3'd2.
  - MFC=1 in the same cycle as the timeout condition wins and goes to CAPTURE.
- RAM_OpCode write bit = (op==10). Signed bit = ld_signed for loads only.
- Store data must already be in MDR (control unit loads it via MDR_Mux_select=0 beforehand); this block never enables MDR for stores.
- trap_tt clears to 0 on each accepted req.

## Timing

- Reset: state=IDLE, counter=0, latched fields=0. All outputs are 0, including trap_tt=3'd0 and RAM_OpCode=6'd0.
- Clr asserted mid-operation aborts immediately. All strobes drop asynchronously and no done or trap pulse follows.
- Outputs are Moore, decoded from the state register and latched fields only. No combinational path from req/MFC to outputs.
- Minimum latency: req high at edge 0 → LOAD_MAR in cycle 1 → ACCESS cycle 2 (MFC=1) → CAPTURE cycle 3 → done=1 in cycle 4. Next req can be accepted at the edge ending cycle 5 (IDLE).
- Each extra MFC-low ACCESS cycle adds one cycle.
- Timeout trap pulses TIMEOUT+2 cycles after acceptance (cycle TIMEOUT+2).
- Misalignment trap pulses in cycle 2.
- Exactly one of done/trap_valid pulses per accepted request.

## Structure

- Package mem_seq_pkg holds:
  - op codes (OP_FETCH/OP_LOAD/OP_STORE);
  - size codes;
  - state enum (IDLE, LOAD_MAR, ACCESS, CAPTURE, DONE, TRAP);
  - trap codes TT_MISALIGN=3'd1, TT_TIMEOUT=3'd2;
  - the RAM_OpCode field layout.
- One natural sub-module: mem_timeout_counter (clear, enable, terminal-count output, width $clog2(TIMEOUT)).
- The FSM and output decode stay in mem_access_seq.

## Test plan

- Fetch, addr_low=00, MFC=1 immediately:
  - MAR_Enable in cycle 1;
  - RAM_enable cycles 2–3 with RAM_OpCode=6'b000010;
  - IR_Enable in cycle 3, done in cycle 4.
- Signed halfword load, addr_low=10, MFC after 3 wait cycles:
  - RAM_OpCode=6'b001001;
  - MDR_Enable=MDR_Mux_select=1 one cycle after MFC sampled;
  - done in cycle 7.
- Word store, addr_low=01 → trap_valid in cycle 2 with trap_tt=1; RAM_enable never high; no done.
- Byte load, MFC held 0 (TIMEOUT=15) → trap_valid in cycle 17 with trap_tt=2. Repeat with MFC=1 exactly in the last ACCESS cycle → CAPTURE and done, no trap.
- Clr pulsed during ACCESS → all outputs 0 immediately, IDLE. A new fetch after reset completes normally; req pulses during busy are ignored.
